// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: sequencer for a programmable clock-pulse divider.
// Walks a DEPTH-entry table of (divisor k, pulse count). Each valid entry
// drives k to the divider and counts rising edges of the divider pulse. Once
// the count is reached the sequencer moves to the next entry. Entries with
// k < 2 or count == 0 are skipped in a single LOAD cycle.
// Optional feature macro PULSE_SEQ_LOOP_EN: the last entry wraps back to
// entry 0 and the sequence repeats until abort. A pass that ran no valid
// entry ends in DONE, so an all-invalid table cannot spin forever.
module pulse_seq_ctrl #(
   parameter int DEPTH = 4,
   parameter int KW    = 32,
   parameter int CW    = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [KW-1:0] cfg_k,
   input  logic [CW-1:0] cfg_cnt,
   input  logic          start,
   input  logic          abort,
   input  logic          pulse_in,
   output logic [KW-1:0] k_out,
   output logic          pulse_out,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] cur_idx,
   output logic [CW-1:0] pulse_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_e;

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] cur_idx_q, cur_idx_d;
   logic [CW-1:0] pulse_cnt_q, pulse_cnt_d;
   logic [KW-1:0] k_out_q, k_out_d;
   logic          pulse_d_q, pulse_d_d;
`ifdef PULSE_SEQ_LOOP_EN
   logic          any_run_q, any_run_d;
`endif

   logic [KW-1:0] tab_k_q   [DEPTH];
   logic [CW-1:0] tab_cnt_q [DEPTH];

   logic          tab_we;
   logic [KW-1:0] ent_k;
   logic [CW-1:0] ent_cnt;
   logic [CW-1:0] cnt_inc;
   logic          edge_det;
   logic          advance;

   // Table writes are only accepted while the sequencer is idle.
   assign tab_we   = cfg_we && (state_q == S_IDLE);
   assign ent_k    = tab_k_q[cur_idx_q];
   assign ent_cnt  = tab_cnt_q[cur_idx_q];
   assign cnt_inc  = pulse_cnt_q + CW'(1);
   assign edge_det = pulse_in & ~pulse_d_q;

   // Table storage. It is cleared on reset so an unwritten entry reads as invalid.
   // NOTE: this array is reset on purpose because k=0/cnt=0 after reset is
   // observable behaviour; a plain storage RAM would normally carry no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tab_k_q[i]   <= '0;
            tab_cnt_q[i] <= '0;
         end
      end else if (tab_we) begin
         tab_k_q[cfg_addr]   <= cfg_k;
         tab_cnt_q[cfg_addr] <= cfg_cnt;
      end
   end

   // State register and datapath registers.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cur_idx_q   <= '0;
         pulse_cnt_q <= '0;
         k_out_q     <= '0;
         pulse_d_q   <= 1'b0;
`ifdef PULSE_SEQ_LOOP_EN
         any_run_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cur_idx_q   <= cur_idx_d;
         pulse_cnt_q <= pulse_cnt_d;
         k_out_q     <= k_out_d;
         pulse_d_q   <= pulse_d_d;
`ifdef PULSE_SEQ_LOOP_EN
         any_run_q   <= any_run_d;
`endif
      end
   end

   // Next-state logic: entry load/skip, edge counting, advance and abort.
   // NOTE: every signal written here gets a hold/default value first, so no
   // path through the block leaves one unassigned (which would infer a latch).
   always_comb begin
      state_d     = state_q;
      cur_idx_d   = cur_idx_q;
      pulse_cnt_d = pulse_cnt_q;
      k_out_d     = k_out_q;
      pulse_d_d   = pulse_in;
      advance     = 1'b0;
`ifdef PULSE_SEQ_LOOP_EN
      any_run_d   = any_run_q;
`endif

      if (abort) begin
         // Abort overrides start, counting and advance; k_out is retained.
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d   = S_LOAD;
                  cur_idx_d = '0;
`ifdef PULSE_SEQ_LOOP_EN
                  any_run_d = 1'b0;
`endif
               end
            end
            S_LOAD: begin
               if ((ent_k < KW'(2)) || (ent_cnt == '0)) begin
                  advance = 1'b1;
               end else begin
                  k_out_d     = ent_k;
                  pulse_cnt_d = '0;
                  // Treat the input as already high so a pulse that is
                  // in progress at entry start is not counted.
                  pulse_d_d   = 1'b1;
                  state_d     = S_RUN;
`ifdef PULSE_SEQ_LOOP_EN
                  any_run_d   = 1'b1;
`endif
               end
            end
            S_RUN: begin
               if (edge_det) begin
                  pulse_cnt_d = cnt_inc;
                  if (cnt_inc == ent_cnt) advance = 1'b1;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase

         if (advance) begin
            if (cur_idx_q != LAST_IDX) begin
               cur_idx_d = cur_idx_q + AW'(1);
               state_d   = S_LOAD;
            end else begin
`ifdef PULSE_SEQ_LOOP_EN
               // Wrap only when this pass ran at least one valid entry.
               if (any_run_q) begin
                  cur_idx_d = '0;
                  any_run_d = 1'b0;
                  state_d   = S_LOAD;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end
         end
      end
   end

   assign k_out     = k_out_q;
   assign pulse_out = pulse_in & (state_q == S_RUN);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign cur_idx   = cur_idx_q;
   assign pulse_cnt = pulse_cnt_q;

endmodule
